// File: rtl/key_filter_pkg.sv
// Shared constants and width helper for the key_filter_multi debouncer family.
package key_filter_pkg;

  localparam logic KEY_RELEASED = 1'b1;
  localparam logic KEY_PRESSED  = 1'b0;

  // 20 ms debounce and 1 s long press at 50 MHz
  localparam int DB_CYCLES_50MHZ   = 32'd1_000_000;
  localparam int LONG_CYCLES_50MHZ = 32'd50_000_000;

  function automatic int cnt_width(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One debounce channel: 2-flop synchroniser, debounce counter, optional hold counter.
// Hold counter and key_long logic are built only when KEY_FILTER_LONG_EN is defined.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_50MHZ,
  parameter int LONG_CYCLES = LONG_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_flag,
  output logic key_press,
  output logic key_long
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_cfg
    $error("key_filter_ch: DB_CYCLES must be >= 2 and LONG_CYCLES > DB_CYCLES");
  end

  logic          sync1_r;
  logic          sync2_r;
  logic          key_s;
  logic [CW-1:0] cnt_r;
  logic          state_r;
  logic          flag_r;
  logic          press_r;
  logic          accept_s;

  assign key_s    = sync2_r;
  assign accept_s = (key_s != state_r) && (cnt_r == CNT_LAST);

  // Two-flop synchroniser for the asynchronous key input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter; any return to the current level restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= '0;
      state_r <= KEY_RELEASED;
      flag_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      flag_r  <= accept_s;
      press_r <= accept_s && (key_s == KEY_PRESSED);
      if (key_s == state_r) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        state_r <= key_s;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

`ifdef KEY_FILTER_LONG_EN
  localparam int HW = cnt_width(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HCNT_FIRE = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HCNT_SAT  = HW'(LONG_CYCLES);

  logic [HW-1:0] hcnt_r;
  logic          long_r;

  // Hold counter saturates one past the fire point so key_long fires once per hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r <= '0;
      long_r <= 1'b0;
    end else begin
      long_r <= (state_r == KEY_PRESSED) && !accept_s && (hcnt_r == HCNT_FIRE);
      if ((state_r == KEY_RELEASED) || accept_s) begin
        hcnt_r <= '0;
      end else if (hcnt_r != HCNT_SAT) begin
        hcnt_r <= hcnt_r + HW'(1);
      end else begin
        hcnt_r <= hcnt_r;
      end
    end
  end

  assign key_long = long_r;
`else
  assign key_long = 1'b0;
`endif

  assign key_state = state_r;
  assign key_flag  = flag_r;
  assign key_press = press_r;

endmodule

// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: KEY_NUM independent key_filter_ch instances.
// Define KEY_FILTER_LONG_EN to build the long-press detector; otherwise key_long is 0.
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int KEY_NUM     = 4,
  parameter int DB_CYCLES   = DB_CYCLES_50MHZ,
  parameter int LONG_CYCLES = LONG_CYCLES_50MHZ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_n,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_flag,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_long
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_filter_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n    (key_n[i]),
      .key_state(key_state[i]),
      .key_flag (key_flag[i]),
      .key_press(key_press[i]),
      .key_long (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi with KEY_NUM=2, DB_CYCLES=16, LONG_CYCLES=64.
module tb_key_filter_multi;

`ifdef KEY_FILTER_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] key_n;
  logic [1:0] key_state;
  logic [1:0] key_flag;
  logic [1:0] key_press;
  logic [1:0] key_long;

  int total;
  int bad;

  key_filter_multi #(
    .KEY_NUM    (2),
    .DB_CYCLES  (16),
    .LONG_CYCLES(64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .key_state(key_state),
    .key_flag (key_flag),
    .key_press(key_press),
    .key_long (key_long)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    key_n = 2'b11;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    total++;
    if ({key_state, key_flag, key_press, key_long} !== 8'b11_00_00_00) begin
      bad++;
      $display("FAIL reset_hold: got=%b exp=%b", {key_state, key_flag, key_press, key_long}, 8'b11_00_00_00);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      total++;
      if ({key_state, key_flag, key_press, key_long} !== 8'b11_00_00_00) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, 8'b11_00_00_00);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [7:0] exp;
    key_n = 2'b10;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp = {(i >= 18) ? 2'b10 : 2'b11, (i == 18) ? 2'b01 : 2'b00, (i == 18) ? 2'b01 : 2'b00, 2'b00};
      total++;
      if ({key_state, key_flag, key_press, key_long} !== exp) begin
        bad++;
        $display("FAIL clean_press cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, exp);
      end
    end
    key_n = 2'b11;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp = {(i >= 18) ? 2'b11 : 2'b10, (i == 18) ? 2'b01 : 2'b00, 2'b00, 2'b00};
      total++;
      if ({key_state, key_flag, key_press, key_long} !== exp) begin
        bad++;
        $display("FAIL clean_release cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, exp);
      end
    end
  endtask

  task automatic test_bounce;
    int seg[10] = '{5, 3, 7, 4, 3, 10, 6, 3, 8, 5};
    logic [7:0] exp;
    for (int s = 0; s < 10; s++) begin
      key_n = (s % 2 == 0) ? 2'b10 : 2'b11;
      for (int j = 0; j < seg[s]; j++) begin
        step();
        total++;
        if ({key_state, key_flag, key_press, key_long} !== 8'b11_00_00_00) begin
          bad++;
          $display("FAIL bounce_quiet seg=%0d: got=%b exp=%b", s, {key_state, key_flag, key_press, key_long}, 8'b11_00_00_00);
        end
      end
    end
    key_n = 2'b10;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp = {(i >= 18) ? 2'b10 : 2'b11, (i == 18) ? 2'b01 : 2'b00, (i == 18) ? 2'b01 : 2'b00, 2'b00};
      total++;
      if ({key_state, key_flag, key_press, key_long} !== exp) begin
        bad++;
        $display("FAIL bounce_press cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, exp);
      end
    end
    key_n = 2'b11;
    for (int i = 0; i < 25; i++) step();
    total++;
    if (key_state !== 2'b11) begin
      bad++;
      $display("FAIL bounce_release: got=%b exp=%b", key_state, 2'b11);
    end
  endtask

  task automatic test_glitch;
    key_n = 2'b01;
    for (int i = 1; i <= 40; i++) begin
      if (i == 11) key_n = 2'b11;
      step();
      total++;
      if ({key_state, key_flag, key_press, key_long} !== 8'b11_00_00_00) begin
        bad++;
        $display("FAIL glitch cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, 8'b11_00_00_00);
      end
    end
  endtask

  task automatic test_both;
    logic [7:0] exp;
    key_n = 2'b00;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp = {(i >= 18) ? 2'b00 : 2'b11, (i == 18) ? 2'b11 : 2'b00, (i == 18) ? 2'b11 : 2'b00, 2'b00};
      total++;
      if ({key_state, key_flag, key_press, key_long} !== exp) begin
        bad++;
        $display("FAIL both_press cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, exp);
      end
    end
    key_n = 2'b11;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp = {(i >= 18) ? 2'b11 : 2'b00, (i == 18) ? 2'b11 : 2'b00, 2'b00, 2'b00};
      total++;
      if ({key_state, key_flag, key_press, key_long} !== exp) begin
        bad++;
        $display("FAIL both_release cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, exp);
      end
    end
  endtask

  task automatic test_long;
    logic [7:0] exp;
    for (int r = 0; r < 2; r++) begin
      key_n = 2'b10;
      for (int i = 1; i <= ((r == 0) ? 200 : 100); i++) begin
        step();
        exp = {(i >= 18) ? 2'b10 : 2'b11, (i == 18) ? 2'b01 : 2'b00, (i == 18) ? 2'b01 : 2'b00,
               (LONG_EN && i == 82) ? 2'b01 : 2'b00};
        total++;
        if ({key_state, key_flag, key_press, key_long} !== exp) begin
          bad++;
          $display("FAIL long_hold round=%0d cyc=%0d: got=%b exp=%b", r, i, {key_state, key_flag, key_press, key_long}, exp);
        end
      end
      key_n = 2'b11;
      for (int i = 1; i <= 25; i++) begin
        step();
        exp = {(i >= 18) ? 2'b11 : 2'b10, (i == 18) ? 2'b01 : 2'b00, 2'b00, 2'b00};
        total++;
        if ({key_state, key_flag, key_press, key_long} !== exp) begin
          bad++;
          $display("FAIL long_release round=%0d cyc=%0d: got=%b exp=%b", r, i, {key_state, key_flag, key_press, key_long}, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [7:0] exp;
    key_n = 2'b10;
    for (int i = 0; i < 30; i++) step();
    total++;
    if (key_state !== 2'b10) begin
      bad++;
      $display("FAIL rst_pre_hold: got=%b exp=%b", key_state, 2'b10);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({key_state, key_flag, key_press, key_long} !== 8'b11_00_00_00) begin
      bad++;
      $display("FAIL rst_async: got=%b exp=%b", {key_state, key_flag, key_press, key_long}, 8'b11_00_00_00);
    end
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      exp = {(i >= 18) ? 2'b10 : 2'b11, (i == 18) ? 2'b01 : 2'b00, (i == 18) ? 2'b01 : 2'b00, 2'b00};
      total++;
      if ({key_state, key_flag, key_press, key_long} !== exp) begin
        bad++;
        $display("FAIL rst_repress cyc=%0d: got=%b exp=%b", i, {key_state, key_flag, key_press, key_long}, exp);
      end
    end
    key_n = 2'b11;
    for (int i = 0; i < 25; i++) step();
    total++;
    if (key_state !== 2'b11) begin
      bad++;
      $display("FAIL rst_release: got=%b exp=%b", key_state, 2'b11);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    key_n = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_both();
    test_long();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
